// File: rtl/template_pkg.sv
// Shared constants and the multi-lane info bus type for the valid counter.
package template_pkg;
    localparam int CNT_WIDTH  = 8;
    localparam int NUM_LANES  = 2;
    localparam int ADDR_WIDTH = 8;
    localparam int INC_W      = $clog2(NUM_LANES + 1);

    typedef struct packed {
        logic [NUM_LANES-1:0]                 vld;
        logic [NUM_LANES-1:0][ADDR_WIDTH-1:0] addr;
    } info_t;
endpackage

// File: rtl/vld_counter_lane_qual.sv
// Per-lane qualification and popcount of the info bus (purely combinational).
// The address window is only built when ADDR_FILTER_EN is defined.
module lane_qual
    import template_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] ADDR_LO = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HI = 8'h7F
) (
    input  info_t            info,
    output logic [INC_W-1:0] inc
);
    logic [NUM_LANES-1:0] qual;

`ifdef ADDR_FILTER_EN
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign qual[i] = info.vld[i] &&
                         (info.addr[i] >= ADDR_LO) && (info.addr[i] <= ADDR_HI);
    end
`else
    // Address is don't-care in this build; sink it so no logic hangs off it.
    logic unused_addr;
    assign unused_addr = ^info.addr;
    assign qual        = info.vld;
`endif

    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_LANES; i++)
            inc = inc + INC_W'(qual[i]);
    end
endmodule

// File: rtl/vld_counter.sv
// Modulo-(CNT_MAX+1) event counter advanced by qualified valid lanes; pulses
// end_cnt_o on wrap. Optional address window via `define ADDR_FILTER_EN.
module vld_counter
    import template_pkg::*;
#(
    parameter int                    CNT_MAX = 99,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LO = 8'h00,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HI = 8'h7F
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flag_cnt,
    input  info_t                info,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 end_cnt_o
);
    localparam logic [CNT_WIDTH:0] MAX_EXT = (CNT_WIDTH + 1)'(CNT_MAX);

    logic [INC_W-1:0]     inc;
    logic [CNT_WIDTH:0]   sum;
    logic                 wrap;
    logic [CNT_WIDTH-1:0] cnt_nxt;

    lane_qual #(
        .ADDR_LO (ADDR_LO),
        .ADDR_HI (ADDR_HI)
    ) u_lane_qual (
        .info (info),
        .inc  (inc)
    );

    // One extra bit so CNT_MAX = 2^CNT_WIDTH-1 still detects the wrap.
    assign sum     = {1'b0, cnt_o} + (CNT_WIDTH + 1)'(inc);
    assign wrap    = sum > MAX_EXT;
    assign cnt_nxt = wrap ? CNT_WIDTH'(sum - (MAX_EXT + 1'b1)) : CNT_WIDTH'(sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_o     <= '0;
            end_cnt_o <= 1'b0;
        end else if (flag_cnt) begin
            cnt_o     <= cnt_nxt;
            end_cnt_o <= wrap;
        end else begin
            end_cnt_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vld_counter.sv
// Directed + random bench for vld_counter with a scoreboard of expected outputs.
module tb_vld_counter;
    import template_pkg::*;

    localparam int MAXC = 99;

    typedef struct {
        logic [7:0] cnt;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_cnt = 1'b0;
    info_t      info = '0;
    logic [7:0] cnt_o;
    logic       end_cnt_o;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ref_cnt = 0;
    int   ref_wraps = 0;
    int   seen_pulses = 0;

    vld_counter #(.CNT_MAX(MAXC), .ADDR_LO(8'h00), .ADDR_HI(8'h7F)) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_cnt  (flag_cnt),
        .info      (info),
        .cnt_o     (cnt_o),
        .end_cnt_o (end_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit lane_ok(input logic v, input logic [7:0] a);
`ifdef ADDR_FILTER_EN
        return v && (a <= 8'h7F);
`else
        return v;
`endif
    endfunction

    // Drive one cycle, push the model's prediction, compare after the edge.
    task automatic step(input logic f, input logic [1:0] v, input logic [7:0] a0,
                        input logic [7:0] a1, input string tag);
        exp_t x;
        int   s;
        flag_cnt     = f;
        info.vld     = v;
        info.addr[0] = a0;
        info.addr[1] = a1;
        x.e = 1'b0;
        if (rst) begin
            ref_cnt = 0;
        end else if (f) begin
            s = ref_cnt + int'(lane_ok(v[0], a0)) + int'(lane_ok(v[1], a1));
            if (s > MAXC) begin
                ref_cnt = s - (MAXC + 1);
                x.e = 1'b1;
                ref_wraps++;
            end else begin
                ref_cnt = s;
            end
        end
        x.cnt = 8'(ref_cnt);
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            x = sb.pop_front();
            chk({tag, "_cnt"}, int'(cnt_o), int'(x.cnt));
            chk({tag, "_end"}, int'(end_cnt_o), int'(x.e));
        end
        if (end_cnt_o === 1'b1) seen_pulses++;
    endtask

    initial begin
        int wraps0;
        // Reset held with live stimulus
        for (int i = 0; i < 3; i++)
            step(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), "rst_hold");
        rst = 1'b0;

        // Increment sequence 1,3,3,4
        step(1'b1, 2'b01, 8'h00, 8'h00, "inc_a");
        step(1'b1, 2'b11, 8'h00, 8'h00, "inc_b");
        step(1'b1, 2'b00, 8'h00, 8'h00, "inc_c");
        step(1'b1, 2'b10, 8'h00, 8'h00, "inc_d");
        chk("inc_is4", int'(cnt_o), 4);
        step(1'b1, 2'b01, 8'h00, 8'h00, "to5");

        // Hold with lanes active
        for (int i = 0; i < 10; i++) step(1'b0, 2'b11, 8'h00, 8'h00, "hold");
        chk("hold_is5", int'(cnt_o), 5);

        // 5 -> 97, then exact landing on 99 is not a wrap
        for (int i = 0; i < 46; i++) step(1'b1, 2'b11, 8'h00, 8'h00, "ramp97");
        step(1'b1, 2'b11, 8'h00, 8'h00, "land99");
        chk("land99_cnt", int'(cnt_o), 99);
        step(1'b1, 2'b01, 8'h00, 8'h00, "wrap99");
        chk("wrap99_end", int'(end_cnt_o), 1);

        // 0 -> 98, wrap by 2, pulse lasts one cycle
        for (int i = 0; i < 49; i++) step(1'b1, 2'b11, 8'h00, 8'h00, "ramp98");
        step(1'b1, 2'b11, 8'h00, 8'h00, "wrap98");
        chk("wrap98_end", int'(end_cnt_o), 1);
        step(1'b1, 2'b00, 8'h00, 8'h00, "wrap98_after");

        // Async reset mid-cycle drops an in-flight pulse
        for (int i = 0; i < 49; i++) step(1'b1, 2'b11, 8'h00, 8'h00, "ramp98b");
        step(1'b1, 2'b11, 8'h00, 8'h00, "wrap98b");
        #2 rst = 1'b1;
        #1;
        chk("async_cnt", int'(cnt_o), 0);
        chk("async_end", int'(end_cnt_o), 0);
        step(1'b1, 2'b11, 8'h00, 8'h00, "async_hold");
        rst = 1'b0;

        // Address window: lane1 at 8'h80 is outside the window
        step(1'b1, 2'b11, 8'h10, 8'h80, "filt");
`ifdef ADDR_FILTER_EN
        chk("filt_inc", int'(cnt_o), 1);
`else
        chk("filt_inc", int'(cnt_o), 2);
`endif

        // Random soak, 100 cycles
        wraps0 = ref_wraps;
        seen_pulses = 0;
        for (int i = 0; i < 100; i++)
            step(1'b1, 2'($urandom), 8'($urandom), 8'($urandom), "soak");
        chk("soak_pulses", seen_pulses, ref_wraps - wraps0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
